// File: rtl/pipe_in_pattern_checker.sv
// Pipe-in pattern checker: drains an okPipeIn FIFO under a rotating
// throttle mask and checks each word against one of four patterns.
//
// Ports:
//   clk, reset_n        endpoint clock, async active-low reset
//   restart             sync pulse: reload generator, clear counters
//   mode[1:0]           0 counter, 1 LFSR, 2 walking-one, 3 0x55/0xAA
//   throttle_set/_val   load throttle mask (else it rotates right)
//   fifo_read           read strobe (combinational)
//   fifo_data/_valid    FIFO word and qualifier
//   fifo_empty          FIFO empty flag
//   error_count         saturating mismatch count
//   word_count          saturating checked-word count
//   error_flag          sticky mismatch flag
//   first_err_index/_data  first mismatch capture
//                       (only with PIPE_CHK_ERR_LOG_EN defined)
module pipe_in_pattern_checker #(
    parameter int          DATA_W    = 64,
    parameter int          CNT_W     = 32,
    parameter logic [31:0] LFSR_SEED = 32'h0D0C0B0A
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              restart,
    input  logic [1:0]        mode,
    input  logic              throttle_set,
    input  logic [31:0]       throttle_val,
    output logic              fifo_read,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_valid,
    input  logic              fifo_empty,
    output logic [CNT_W-1:0]  error_count,
    output logic [CNT_W-1:0]  word_count,
    output logic              error_flag
`ifdef PIPE_CHK_ERR_LOG_EN
    ,
    output logic [CNT_W-1:0]  first_err_index,
    output logic [DATA_W-1:0] first_err_data
`endif
);

    localparam int L = DATA_W / 32;
    localparam logic [DATA_W-1:0] D_ONE = DATA_W'(1);
    localparam logic [CNT_W-1:0]  C_ONE = CNT_W'(1);

    function automatic logic [DATA_W-1:0] gen_init(
        input logic [1:0] m
    );
        logic [DATA_W-1:0] w;
        w = '0;
        unique case (m)
            2'd0: w = D_ONE;
            2'd1: begin
                for (int k = 0; k < L; k++) begin
                    w[32*k +: 32] = LFSR_SEED + 32'(k);
                end
            end
            2'd2: w = D_ONE;
            2'd3: w = {(DATA_W/8){8'h55}};
        endcase
        return w;
    endfunction

    function automatic logic [DATA_W-1:0] gen_next(
        input logic [1:0]        m,
        input logic [DATA_W-1:0] w
    );
        logic [DATA_W-1:0] nw;
        logic [31:0]       s;
        nw = w;
        unique case (m)
            2'd0: nw = w + D_ONE;
            2'd1: begin
                for (int k = 0; k < L; k++) begin
                    s = w[32*k +: 32];
                    nw[32*k +: 32] =
                        {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
                end
            end
            2'd2: nw = {w[DATA_W-2:0], w[DATA_W-1]};
            2'd3: nw = ~w;
        endcase
        return nw;
    endfunction

    logic [31:0]       thr_q;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] exp_q;
    logic [CNT_W-1:0]  err_q;
    logic [CNT_W-1:0]  wc_q;
    logic              flag_q;
    logic              mismatch;

    assign mismatch = (fifo_data != exp_q);

    // Read is gated by the current throttle bit, not the next one.
    assign fifo_read = reset_n && !fifo_empty &&
                       thr_q[0] && !restart;

    assign error_count = err_q;
    assign word_count  = wc_q;
    assign error_flag  = flag_q;

`ifdef PIPE_CHK_ERR_LOG_EN
    logic [CNT_W-1:0]  fidx_q;
    logic [DATA_W-1:0] fdata_q;

    assign first_err_index = fidx_q;
    assign first_err_data  = fdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fidx_q  <= '0;
            fdata_q <= '0;
        end else if (restart) begin
            fidx_q  <= '0;
            fdata_q <= '0;
        end else if (fifo_valid && mismatch && !flag_q) begin
            fidx_q  <= wc_q;
            fdata_q <= fifo_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            thr_q  <= '1;
            mode_q <= 2'd0;
            exp_q  <= gen_init(2'd0);
            err_q  <= '0;
            wc_q   <= '0;
            flag_q <= 1'b0;
        end else begin
            // Throttle keeps running through restart.
            if (throttle_set) begin
                thr_q <= throttle_val;
            end else begin
                thr_q <= {thr_q[0], thr_q[31:1]};
            end
            if (restart) begin
                mode_q <= mode;
                exp_q  <= gen_init(mode);
                err_q  <= '0;
                wc_q   <= '0;
                flag_q <= 1'b0;
            end else if (fifo_valid) begin
                exp_q <= gen_next(mode_q, exp_q);
                if (wc_q != '1) begin
                    wc_q <= wc_q + C_ONE;
                end
                if (mismatch) begin
                    flag_q <= 1'b1;
                    if (err_q != '1) begin
                        err_q <= err_q + C_ONE;
                    end
                end
            end
        end
    end

endmodule
